// File: rtl/hazard_if.sv
// Pipeline-side view of the hazard controller: pipeline-register fields in, stall/flush/forward controls out.
interface hazard_if #(parameter int CNT_W = 16);
    logic             id_valid, id_use_rs1, id_use_rs2;
    logic [4:0]       id_rs1, id_rs2;
    logic             ex_valid, ex_regwrite, ex_is_load, ex_redirect;
    logic [4:0]       ex_rd, ex_rs1, ex_rs2;
    logic             mem_valid, mem_regwrite, mem_req, mem_ready;
    logic [4:0]       mem_rd;
    logic             wb_valid, wb_regwrite;
    logic [4:0]       wb_rd;
    logic             pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
    logic             if_id_flush, id_ex_flush, mem_wb_bubble;
    logic [1:0]       fwd_a, fwd_b;
    logic             id_byp_a, id_byp_b;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    modport master (
        output id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
               ex_valid, ex_regwrite, ex_is_load, ex_redirect, ex_rd, ex_rs1, ex_rs2,
               mem_valid, mem_regwrite, mem_req, mem_ready, mem_rd,
               wb_valid, wb_regwrite, wb_rd,
        input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_bubble,
               fwd_a, fwd_b, id_byp_a, id_byp_b, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_use_rs1, id_use_rs2, id_rs1, id_rs2,
               ex_valid, ex_regwrite, ex_is_load, ex_redirect, ex_rd, ex_rs1, ex_rs2,
               mem_valid, mem_regwrite, mem_req, mem_ready, mem_rd,
               wb_valid, wb_regwrite, wb_rd,
        output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
               if_id_flush, id_ex_flush, mem_wb_bubble,
               fwd_a, fwd_b, id_byp_a, id_byp_b, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline: combinational stall/flush/forward, registered MEM-wait FSM and perf counters.
// HAZ_FWD_EN defined enables EX forwarding and ID bypass; undefined falls back to full RAW interlock.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    hazard_if.slave  hz
);
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_q, flush_q;

    function automatic logic hit(input logic v, input logic w,
                                 input logic [4:0] rd, input logic [4:0] s);
        return v && w && (rd == s) && (s != 5'd0);
    endfunction

    logic rs1_chk, rs2_chk, mem_wait, redirect, dep, dep_stall;

    assign rs1_chk  = hz.id_valid && hz.id_use_rs1;
    assign rs2_chk  = hz.id_valid && hz.id_use_rs2;
    assign mem_wait = (hz.mem_req && !hz.mem_ready) || (state_q == ERR);
    assign redirect = hz.ex_redirect && !mem_wait;

`ifdef HAZ_FWD_EN
    assign dep = hz.ex_is_load &&
                 ((rs1_chk && hit(hz.ex_valid, hz.ex_regwrite, hz.ex_rd, hz.id_rs1)) ||
                  (rs2_chk && hit(hz.ex_valid, hz.ex_regwrite, hz.ex_rd, hz.id_rs2)));
`else
    // Without forwarding, any in-flight writer of an ID source blocks it until it has left WB.
    assign dep = (rs1_chk && (hit(hz.ex_valid,  hz.ex_regwrite,  hz.ex_rd,  hz.id_rs1) ||
                              hit(hz.mem_valid, hz.mem_regwrite, hz.mem_rd, hz.id_rs1) ||
                              hit(hz.wb_valid,  hz.wb_regwrite,  hz.wb_rd,  hz.id_rs1))) ||
                 (rs2_chk && (hit(hz.ex_valid,  hz.ex_regwrite,  hz.ex_rd,  hz.id_rs2) ||
                              hit(hz.mem_valid, hz.mem_regwrite, hz.mem_rd, hz.id_rs2) ||
                              hit(hz.wb_valid,  hz.wb_regwrite,  hz.wb_rd,  hz.id_rs2)));
    logic unused_ex_srcs;
    assign unused_ex_srcs = ^{hz.ex_rs1, hz.ex_rs2, hz.ex_is_load};
`endif

    assign dep_stall = dep && !mem_wait && !redirect;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // wcnt_q counts consecutive unfinished wait cycles, including the one that entered MEMWAIT.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    wcnt_d  = WCW'(1);
                    state_d = (MEM_TIMEOUT <= 1) ? ERR : MEMWAIT;
                end
            end
            MEMWAIT: begin
                if (hz.mem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q >= WCW'(MEM_TIMEOUT - 1)) begin
                    state_d = ERR;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        hz.pc_stall      = 1'b0;
        hz.if_id_stall   = 1'b0;
        hz.id_ex_stall   = 1'b0;
        hz.ex_mem_stall  = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_flush   = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        hz.fwd_a         = 2'b00;
        hz.fwd_b         = 2'b00;
        hz.id_byp_a      = 1'b0;
        hz.id_byp_b      = 1'b0;
        if (rst_n) begin
            hz.pc_stall      = mem_wait || dep_stall;
            hz.if_id_stall   = mem_wait || dep_stall;
            hz.id_ex_stall   = mem_wait;
            hz.ex_mem_stall  = mem_wait;
            hz.mem_wb_bubble = mem_wait;
            hz.if_id_flush   = redirect;
            hz.id_ex_flush   = redirect || dep_stall;
`ifdef HAZ_FWD_EN
            if (hit(hz.mem_valid, hz.mem_regwrite, hz.mem_rd, hz.ex_rs1))     hz.fwd_a = 2'b01;
            else if (hit(hz.wb_valid, hz.wb_regwrite, hz.wb_rd, hz.ex_rs1))   hz.fwd_a = 2'b10;
            if (hit(hz.mem_valid, hz.mem_regwrite, hz.mem_rd, hz.ex_rs2))     hz.fwd_b = 2'b01;
            else if (hit(hz.wb_valid, hz.wb_regwrite, hz.wb_rd, hz.ex_rs2))   hz.fwd_b = 2'b10;
            hz.id_byp_a = rs1_chk && hit(hz.wb_valid, hz.wb_regwrite, hz.wb_rd, hz.id_rs1);
            hz.id_byp_b = rs2_chk && hit(hz.wb_valid, hz.wb_regwrite, hz.wb_rd, hz.id_rs2);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hz.pc_stall && !(&stall_q))    stall_q <= stall_q + 1'b1;
            if (hz.if_id_flush && !(&flush_q)) flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.stall_cnt = stall_q;
    assign hz.flush_cnt = flush_q;
    assign hz.mem_err   = (state_q == ERR);
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Detects RAW, load-use, control and data-memory-wait hazards from pipeline-register fields.
- Drives per-stage stall/flush controls and EX operand forwarding selects.
- Tracks memory-wait timeout and saturating performance counters.
- Sits beside the pipeline registers; the core gates its register updates with these outputs.

## Interface
Parameters:
- MEM_TIMEOUT, 64: max consecutive MEM-wait cycles before fatal error.
- CNT_W, 16: width of performance counters.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid, id_use_rs1, id_use_rs2  in  1 each  ID instruction valid / reads rs1 / reads rs2.
- id_rs1, id_rs2  in  5 each  ID source registers.
- ex_valid, ex_regwrite, ex_is_load  in  1 each  ID/EX fields.
- ex_rd, ex_rs1, ex_rs2  in  5 each  ID/EX register numbers.
- ex_redirect  in  1  taken branch/jump resolved in EX.
- mem_valid, mem_regwrite, mem_req  in  1 each  EX/MEM fields; mem_req = load/store in MEM.
- mem_ready  in  1  data memory completes access this cycle.
- mem_rd  in  5  EX/MEM destination.
- wb_valid, wb_regwrite  in  1 each  MEM/WB fields.
- wb_rd  in  5  MEM/WB destination.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold register.
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  load invalid/bubble.
- fwd_a, fwd_b  out  2 each  EX operand select: 00 ID/EX RD, 01 EX/MEM ALU result, 10 MEM/WB WD.
- id_byp_a, id_byp_b  out  1 each  ID read uses WB write data (same-cycle write/read).
- mem_err  out  1  sticky timeout flag.
- stall_cnt, flush_cnt  out  CNT_W each  saturating counters.

## Operation
- Match(r, s): stage valid && regwrite && rd == s && s != 0. A source is checked only if its id_use_* is set.
- Priority, highest first: ERR, MEM wait, redirect, load-use.
- FSM states: RUN, MEMWAIT, ERR.
- RUN to MEMWAIT: mem_req && !mem_ready.
- MEMWAIT to RUN: mem_ready.
- MEMWAIT to ERR: wait counter reaches MEM_TIMEOUT. ERR exits only on reset.
- MEM wait (mem_req && !mem_ready, or state ERR):
  - pc/if_id/id_ex/ex_mem stall = 1; mem_wb_bubble = 1.
  - Any ex_redirect stays frozen in EX and is honoured on the release cycle.
- Redirect (no MEM wait): if_id_flush = id_ex_flush = 1; PC not stalled, so it loads the target.
- Load-use (no wait/redirect): ex_is_load && Match(EX, id_rs*):
  - pc_stall = if_id_stall = 1; id_ex_flush = 1 (one bubble).
- Forwarding per EX operand: EX/MEM match on ex_rs* selects 01; else MEM/WB match selects 10; else 00.
- id_byp_*: MEM/WB match on id_rs*.
- stall_cnt: +1 each cycle pc_stall is 1.
- flush_cnt: +1 each cycle if_id_flush is 1.
- Both counters saturate at all-ones.
- MEMWAIT wait counter clears on entry to RUN.

## Timing
- All stall/flush/forward/bypass outputs are combinational from inputs and state, valid the same cycle.
- State, wait counter, mem_err and perf counters update on posedge clk.
- Reset (rst_n low, asynchronous): state RUN, counters 0, mem_err 0. All stall/flush/bubble/fwd/byp outputs are forced 0 while rst_n is low.
- Reset mid-MEMWAIT or in ERR: immediate return to RUN; no residual stall after rst_n rises.
- mem_ready in the same cycle as mem_req: no stall, no MEMWAIT entry.
- Load-use costs exactly 1 cycle; the load then forwards from MEM/WB (10).
- Simultaneous redirect and load-use: redirect wins; no stall; instruction in ID is flushed.

## Configuration
- HAZ_FWD_EN defined: forwarding and ID bypass as above.
- HAZ_FWD_EN undefined:
  - fwd_a, fwd_b, id_byp_* tied 0.
  - RAW stall (pc/if_id stall, id_ex_flush) whenever Match(EX|MEM|WB, id_rs*). Load-use is subsumed by this rule.
  - A dependent instruction is released the cycle after its producer leaves WB.

## Test plan
- add x5 in EX, add using x5 in ID (HAZ_FWD_EN) -> next cycle fwd_a=01; no stall; stall_cnt stays 0.
- lw x6 in EX, add x7,x6,x6 in ID -> 1 cycle pc_stall/id_ex_flush; then fwd_a=fwd_b=10; stall_cnt=1.
- beq taken in EX -> if_id_flush=id_ex_flush=1 for 1 cycle; flush_cnt=1; dependency on x0 never forwards.
- mem_req with mem_ready low 3 cycles alongside ex_redirect -> full freeze 3 cycles; redirect flush on release cycle; stall_cnt=3.
- mem_ready held low for MEM_TIMEOUT=64 cycles -> state ERR, mem_err=1, pipeline frozen. rst_n low mid-ERR -> all outputs 0, counters 0.
- HAZ_FWD_EN undefined, back-to-back add x5 / add using x5 -> 3 stall cycles; fwd_* remain 00.
